// File: rtl/chiplet_noc_arb_pkg.sv
// Shared arbitration helpers for the chiplet NoC arbiters.
//   arb_wrap_add  : (a + b) mod n for operands already below n
//   arb_rr_pick   : round-robin pick on an ARB_MAX_N-wide vector, one-hot result
//   onehot_to_idx : binary index of a one-hot vector (0 when empty)
//   weight_vec_t  : packed per-input weight vector at the default port size
package chiplet_noc_arb_pkg;

  localparam int ARB_MAX_N    = 32;
  localparam int ARB_MAX_LOGN = 5;
  localparam int ARB_N        = 4;
  localparam int ARB_WEIGHT_W = 4;

  typedef logic [ARB_MAX_N-1:0]    arb_vec_t;
  typedef logic [ARB_MAX_LOGN-1:0] arb_ptr_t;
  typedef logic [ARB_WEIGHT_W-1:0] weight_t;
  typedef weight_t [ARB_N-1:0]     weight_vec_t;

  function automatic int arb_wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

  function automatic arb_vec_t arb_rr_pick(input arb_vec_t request, input arb_ptr_t ptr,
                                           input int n);
    arb_vec_t rot;
    arb_vec_t pick;
    int       hit;
    int       src;
    rot  = '0;
    pick = '0;
    hit  = -1;
    for (int k = 0; k < ARB_MAX_N; k++) begin
      if (k < n) begin
        src    = arb_wrap_add(32'(ptr), k, n);
        rot[k] = request[src[ARB_MAX_LOGN-1:0]];
      end
    end
    for (int k = ARB_MAX_N - 1; k >= 0; k--) begin
      if (rot[k]) hit = k;
    end
    if (hit >= 0) begin
      src = arb_wrap_add(32'(ptr), hit, n);
      pick[src[ARB_MAX_LOGN-1:0]] = 1'b1;
    end
    return pick;
  endfunction

  function automatic arb_ptr_t onehot_to_idx(input arb_vec_t oh);
    arb_ptr_t idx;
    idx = '0;
    for (int k = 0; k < ARB_MAX_N; k++) begin
      if (oh[k]) idx = idx | ARB_MAX_LOGN'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/chiplet_arbiter_wrr_if.sv
// Handshake bundle between a router output port and its input arbiter.
//   master : router side, drives requests, flit framing and weight config
//   slave  : arbiter side, drives grant, grant_idx, grant_valid, locked, timeout_err
interface chiplet_arbiter_wrr_if #(
  parameter int N        = 4,
  parameter int WEIGHT_W = 4,
  parameter int LOGN     = 2
);
  logic [N-1:0]          request;
  logic                  forwarding_head;
  logic                  forwarding_tail;
  logic [N*WEIGHT_W-1:0] weight_cfg;
  logic                  cfg_valid;
  logic [N-1:0]          grant;
  logic [LOGN-1:0]       grant_idx;
  logic                  grant_valid;
  logic                  locked;
  logic                  timeout_err;

  modport master (
    output request, forwarding_head, forwarding_tail, weight_cfg, cfg_valid,
    input  grant, grant_idx, grant_valid, locked, timeout_err
  );

  modport slave (
    input  request, forwarding_head, forwarding_tail, weight_cfg, cfg_valid,
    output grant, grant_idx, grant_valid, locked, timeout_err
  );
endinterface

// File: rtl/arb_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so ptr sits at
// bit 0, take the lowest set bit, rotate the winner back.
//   i_request   : N request bits
//   i_ptr       : highest-priority input
//   o_grant     : one-hot winner, zero when no request
//   o_grant_idx : binary winner index, zero when no request
module arb_rr_picker
  import chiplet_noc_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int LOGN = 2
) (
  input  logic [N-1:0]    i_request,
  input  logic [LOGN-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic [LOGN-1:0] o_grant_idx
);

  logic [N-1:0]    w_rot;
  logic [LOGN-1:0] w_rot_idx;
  logic            w_any;
  logic [LOGN-1:0] w_idx;

  always_comb begin
    w_rot = '0;
    for (int k = 0; k < N; k++) begin
      w_rot[k] = i_request[LOGN'(arb_wrap_add(32'(i_ptr), k, N))];
    end
  end

  always_comb begin
    w_rot_idx = '0;
    w_any     = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_rot_idx = LOGN'(k);
        w_any     = 1'b1;
      end
    end
  end

  always_comb begin
    w_idx   = '0;
    o_grant = '0;
    if (w_any) begin
      w_idx          = LOGN'(arb_wrap_add(32'(i_ptr), 32'(w_rot_idx), N));
      o_grant[w_idx] = 1'b1;
    end
  end

  assign o_grant_idx = w_idx;

endmodule

// File: rtl/chiplet_arbiter_wrr.sv
// Weighted round-robin wormhole arbiter for one chiplet router output port.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of chiplet_arbiter_wrr_if (requests, flit framing,
//              weight config in; grant, grant_idx, grant_valid, locked,
//              timeout_err out)
// Unlocked, the grant is a combinational round-robin pick from ptr. A head
// flit locks the port to its input until the tail; weight[i] extra packets may
// follow back to back before the pointer moves past input i.
module chiplet_arbiter_wrr
  import chiplet_noc_arb_pkg::*;
#(
  parameter int TILES        = 2,
  parameter int PLANES       = 2,
  parameter int WEIGHT_W     = 4,
  parameter int TIMEOUT_W    = 8,
  parameter int LOCK_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  chiplet_arbiter_wrr_if.slave bus
);

  localparam int N    = TILES * PLANES;
  localparam int LOGN = (N > 1) ? $clog2(N) : 1;

  logic [LOGN-1:0]              r_ptr;
  logic [LOGN-1:0]              r_owner;
  logic [WEIGHT_W-1:0]          r_credits;
  logic                         r_locked;
  logic [N-1:0]                 r_lock_grant;
  logic [TIMEOUT_W-1:0]         r_wdog;
  logic                         r_timeout_err;
  logic [N-1:0][WEIGHT_W-1:0]   r_weight;
  logic [N-1:0][WEIGHT_W-1:0]   r_cfg_shadow;
  logic                         r_cfg_pending;

  logic [N-1:0]                 w_pick_grant;
  logic [LOGN-1:0]              w_pick_idx;
  logic [N-1:0]                 w_grant;
  logic [LOGN-1:0]              w_grant_idx;
  logic                         w_grant_valid;
  logic                         w_head_acc;
  logic                         w_lock_start;
  logic                         w_unlock;
  logic [WEIGHT_W-1:0]          w_credits_nxt;
  logic [LOGN-1:0]              w_ptr_inc;
  logic [TIMEOUT_W-1:0]         w_wdog_nxt;
  logic [N-1:0][WEIGHT_W-1:0]   w_cfg;

  arb_rr_picker #(.N(N), .LOGN(LOGN)) u_picker (
    .i_request   (bus.request),
    .i_ptr       (r_ptr),
    .o_grant     (w_pick_grant),
    .o_grant_idx (w_pick_idx)
  );

  // Outputs are forced low while reset is asserted, even with requests present.
  always_comb begin
    w_grant       = '0;
    w_grant_idx   = '0;
    w_grant_valid = 1'b0;
    if (rst) begin
      if (r_locked) begin
        w_grant       = r_lock_grant;
        w_grant_idx   = r_owner;
        w_grant_valid = bus.request[r_owner];
      end else begin
        w_grant       = w_pick_grant;
        w_grant_idx   = w_pick_idx;
        w_grant_valid = |bus.request;
      end
    end
  end

  assign w_head_acc   = bus.forwarding_head & w_grant_valid;
  assign w_lock_start = w_head_acc & ~bus.forwarding_tail;
  assign w_unlock     = r_locked & bus.forwarding_tail;
  assign w_cfg        = bus.weight_cfg;

  // A repeat turn by the current owner spends a credit; anyone else reloads.
  assign w_credits_nxt = ((w_grant_idx == r_owner) && (r_credits != '0))
                         ? r_credits - WEIGHT_W'(1)
                         : r_weight[w_grant_idx];
  assign w_ptr_inc     = LOGN'(arb_wrap_add(32'(w_grant_idx), 1, N));

  // wdog counts cycles since the head edge and saturates; the error pulse
  // marks the edge on which it steps onto LOCK_TIMEOUT.
  always_comb begin
    w_wdog_nxt = r_wdog;
    if (w_unlock)                    w_wdog_nxt = '0;
    else if (w_lock_start)           w_wdog_nxt = TIMEOUT_W'(1);
    else if (r_locked && !(&r_wdog)) w_wdog_nxt = r_wdog + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr         <= '0;
      r_owner       <= '0;
      r_credits     <= '0;
      r_locked      <= 1'b0;
      r_lock_grant  <= '0;
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
      r_weight      <= '0;
      r_cfg_shadow  <= '0;
      r_cfg_pending <= 1'b0;
    end else begin
      if (w_head_acc) begin
        r_owner      <= w_grant_idx;
        r_credits    <= w_credits_nxt;
        r_ptr        <= (w_credits_nxt == '0) ? w_ptr_inc : w_grant_idx;
        r_lock_grant <= w_grant;
      end

      if (w_lock_start)  r_locked <= 1'b1;
      else if (w_unlock) r_locked <= 1'b0;

      // New weights never touch the credits already loaded for the owner.
      if (bus.cfg_valid) begin
        if (!r_locked || w_unlock) begin
          r_weight      <= w_cfg;
          r_cfg_pending <= 1'b0;
        end else begin
          r_cfg_shadow  <= w_cfg;
          r_cfg_pending <= 1'b1;
        end
      end else if (r_cfg_pending && w_unlock) begin
        r_weight      <= r_cfg_shadow;
        r_cfg_pending <= 1'b0;
      end

      r_wdog        <= w_wdog_nxt;
      r_timeout_err <= (LOCK_TIMEOUT > 0) && (w_wdog_nxt != r_wdog) &&
                       (w_wdog_nxt == TIMEOUT_W'(LOCK_TIMEOUT));
    end
  end

  assign bus.grant       = w_grant;
  assign bus.grant_idx   = w_grant_idx;
  assign bus.grant_valid = w_grant_valid;
  assign bus.locked      = r_locked;
  assign bus.timeout_err = r_timeout_err;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(w_grant));
  a_grant_stable: assert property (@(posedge clk) disable iff (!rst)
    (r_locked && $past(r_locked)) |-> $stable(w_grant));
  a_head_locked: assert property (@(posedge clk) disable iff (!rst)
    (r_locked && w_head_acc) |-> bus.forwarding_tail);
  a_head_valid: assert property (@(posedge clk) disable iff (!rst)
    bus.forwarding_head |-> w_grant_valid);
  a_tail_orphan: assert property (@(posedge clk) disable iff (!rst)
    (bus.forwarding_tail && !r_locked) |-> bus.forwarding_head);

endmodule

// File: doc/chiplet_arbiter_wrr.md
Name: chiplet_arbiter_wrr

Overview:
Successor to the chiplet router input arbiter. It arbitrates TILES*PLANES requesters onto one router output port using wormhole routing, and adds three things: weighted round-robin (a configurable packets-per-turn weight per input), a registered grant that holds across a locked packet, and a lock watchdog that flags a missing tail. It sits in the chiplet NoC router, one instance per output port. Grant is produced with zero cycles of delay.

Parameters:
TILES, 2, number of tiles feeding the port
PLANES, 2, NoC planes per tile; N = TILES*PLANES inputs, LOGN = max(1, $clog2(N))
WEIGHT_W, 4, width of the per-input weight field
TIMEOUT_W, 8, width of the watchdog counter
LOCK_TIMEOUT, 0, maximum locked cycles before an error is flagged; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
request  in  N  bit i = input i has a valid flit for this output
forwarding_head  in  1  head flit of the granted input forwarded this cycle
forwarding_tail  in  1  tail flit forwarded this cycle (may coincide with head for single-flit packets)
weight_cfg  in  N*WEIGHT_W  per-input weight; slice i = extra consecutive packets allowed for input i
cfg_valid  in  1  one-cycle strobe that captures weight_cfg
grant  out  N  one-hot or zero
grant_idx  out  LOGN  binary index of grant; 0 when grant is zero
grant_valid  out  1  grant is usable this cycle
locked  out  1  a packet is in flight (after head, before tail)
timeout_err  out  1  one-cycle pulse when the watchdog expires

Behaviour:
- Reset (rst=0, asynchronous):
  - ptr=0, owner=0, credits=0, locked=0, wdog=0, weights all 0 (plain round-robin), cfg_pending=0.
  - Outputs: grant=0, grant_idx=0, grant_valid=0, locked=0, timeout_err=0.
- Unlocked, combinational:
  - grant = first set bit of request, scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
  - grant_valid = |request.
  - No request: grant=0, grant_idx=0.
- Locked:
  - grant = one-hot(owner), registered, and independent of the request vector.
  - grant_valid = request[owner].
  - Requests from other inputs are ignored.
- Head accepted (forwarding_head=1 and grant_valid=1), with grant index g:
  - If g==owner and credits>0: credits <= credits-1.
  - Otherwise: owner <= g and credits <= weight[g].
  - If the resulting credits==0: ptr <= (g+1) mod N. Else: ptr <= g, so g keeps top priority.
  - locked <= 1, unless forwarding_tail is also high that cycle (single-flit packet): then locked stays 0 and the credit update still applies.
  - forwarding_head while grant_valid=0 is ignored (assertion).
- Tail while locked: locked <= 0 and wdog <= 0. A tail while unlocked and without a head is ignored (assertion).
- Weight reconfiguration:
  - cfg_valid while unlocked: weights load on the next edge.
  - cfg_valid while locked: the value is held in a shadow register (cfg_pending=1) and applied on the cycle locked falls.
  - A later cfg_valid overwrites the pending value.
  - The credits of the current owner are not recomputed; new weights take effect at that input's next turn.
- Watchdog (LOCK_TIMEOUT>0):
  - wdog increments each cycle while locked, saturating at 2^TIMEOUT_W-1.
  - timeout_err pulses for one cycle on the cycle wdog reaches LOCK_TIMEOUT.
  - The lock is not released; the watchdog only reports.
  - wdog clears on unlock.
- Widths: credits and weights are WEIGHT_W bits; ptr and owner are LOGN bits. Wrap-around is computed mod N for non-power-of-2 N (ptr==N-1 goes to 0).
- Assertions (non-synthesis):
  - $onehot0(grant).
  - grant stable while locked.
  - No head accepted while locked unless the tail is in the same cycle.

Decomposition:
- Shared package chiplet_noc_arb_pkg: function arb_rr_pick(request, ptr) returning a one-hot vector, function onehot_to_idx, and a weight-vector typedef parameterised via localparams.
- One sub-module, arb_rr_picker: a combinational rotate, priority-encode, unrotate picker of width N. It is reused by other chiplet arbiters.
- The top level holds the lock, credit, config-shadow and watchdog sequential logic.

Test Plan:
1. N=4, weights 0, request=4'b1111, 4-flit packets → grant order 0,1,2,3,0; grant holds through each packet; locked drops on tail.
2. weight[1]=2, request=4'b0010|4'b0001 continuously, single-flit packets → input 1 granted 3 consecutive packets, then input 0, then input 1 again.
3. Head and tail in the same cycle with request=4'b1000 → locked stays 0; the next cycle's grant reflects ptr=0.
4. Lock with LOCK_TIMEOUT=5 and no tail → timeout_err is high for exactly one cycle, 5 cycles after the head; grant is unchanged; a subsequent tail unlocks.
5. cfg_valid with weight[2]=3 issued while locked → the old weights stay in force until the tail; the new weight applies from input 2's next turn.
6. Assert rst mid-packet (locked=1, ptr=2) → all outputs are 0 immediately (asynchronously); after release, request=4'b1111 is granted to input 0.
